// File: rtl/col2im_pkg.sv
// col2im_pkg: shared types, default geometry and patch-lane helper for the
// col2im accumulator.
`timescale 1ns/1ps
package col2im_pkg;

  // Frame-level control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    ACCEPT = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Default frame geometry.
  localparam int DEF_INPUT_WIDTH  = 4;
  localparam int DEF_INPUT_HEIGHT = 4;
  localparam int DEF_KERNEL_SIZE  = 3;

  // Number of window origins along each axis for the default geometry.
  localparam int OUTPUT_WIDTH  = DEF_INPUT_WIDTH  - DEF_KERNEL_SIZE + 1;
  localparam int OUTPUT_HEIGHT = DEF_INPUT_HEIGHT - DEF_KERNEL_SIZE + 1;

  // Upper bounds for the generic lane-slice helper.
  localparam int MAX_PATCH_BITS = 4096;
  localparam int MAX_ELEM_BITS  = 64;

  // Window origins along one axis for an arbitrary geometry.
  function automatic int out_dim(input int in_dim, input int k);
    return in_dim - k + 1;
  endfunction

  // Element (i,j) of a K x K patch packed row-major, dw bits per element.
  function automatic logic [MAX_ELEM_BITS-1:0] lane_slice(
    input logic [MAX_PATCH_BITS-1:0] patch,
    input int                        i,
    input int                        j,
    input int                        k,
    input int                        dw
  );
    logic [MAX_PATCH_BITS-1:0] shifted;
    logic [MAX_ELEM_BITS-1:0]  mask;
    shifted = patch >> ((i * k + j) * dw);
    mask    = ~({MAX_ELEM_BITS{1'b1}} << dw);
    return shifted[MAX_ELEM_BITS-1:0] & mask;
  endfunction

endpackage

// File: rtl/col2im_sat_add.sv
// col2im_sat_add: one accumulator lane adder. Zero-extends the patch element
// to AWIDTH and adds it to the current pixel value.
// Build option COL2IM_SAT_EN: when defined the sum clamps to 2^AWIDTH-1,
// otherwise it wraps modulo 2^AWIDTH.
`timescale 1ns/1ps
module col2im_sat_add #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 8
) (
  input  logic [AWIDTH-1:0] acc_i,
  input  logic [DWIDTH-1:0] elem_i,
  output logic [AWIDTH-1:0] sum_o
);

`ifdef COL2IM_SAT_EN
  logic [AWIDTH:0] full_sum;

  // Carry out of the AWIDTH-bit add selects the clamp value.
  always_comb begin
    full_sum = {1'b0, acc_i} + (AWIDTH + 1)'(elem_i);
    sum_o    = full_sum[AWIDTH] ? {AWIDTH{1'b1}} : full_sum[AWIDTH-1:0];
  end
`else
  // Plain modular add.
  always_comb begin
    sum_o = acc_i + AWIDTH'(elem_i);
  end
`endif

endmodule

// File: rtl/col2im_accum.sv
// col2im_accum: scatter-adds raster-ordered K x K patches into an on-chip
// image accumulator, then serves the finished image through a registered
// read port. Build option COL2IM_SAT_EN selects saturating accumulation
// (see col2im_sat_add).
`timescale 1ns/1ps
module col2im_accum
  import col2im_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int INPUT_HEIGHT = DEF_INPUT_HEIGHT,
  parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE,
  parameter int DWIDTH       = 8,
  parameter int AWIDTH       = 12,
  localparam int XW = (INPUT_WIDTH  > 1) ? $clog2(INPUT_WIDTH)  : 1,
  localparam int YW = (INPUT_HEIGHT > 1) ? $clog2(INPUT_HEIGHT) : 1,
  localparam int PW = DWIDTH * KERNEL_SIZE * KERNEL_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PW-1:0]     in_data,
  input  logic              read_en,
  input  logic [XW-1:0]     read_x,
  input  logic [YW-1:0]     read_y,
  output logic [AWIDTH-1:0] read_data,
  output logic              read_valid,
  output logic              busy,
  output logic              done
);

  localparam int OUT_W = out_dim(INPUT_WIDTH,  KERNEL_SIZE);
  localparam int OUT_H = out_dim(INPUT_HEIGHT, KERNEL_SIZE);

  state_t      state_q;
  logic [XW-1:0] win_x_q;
  logic [YW-1:0] win_y_q;
  logic [YW-1:0] clr_row_q;
  logic        in_ready_q;
  logic        busy_q;
  logic        done_q;

  logic [AWIDTH-1:0] acc_q [INPUT_HEIGHT][INPUT_WIDTH];

  logic [DWIDTH-1:0] elem   [KERNEL_SIZE][KERNEL_SIZE];
  logic [AWIDTH-1:0] acc_rd [KERNEL_SIZE][KERNEL_SIZE];
  logic [AWIDTH-1:0] sum    [KERNEL_SIZE][KERNEL_SIZE];
  logic [XW-1:0]     lane_x [KERNEL_SIZE];
  logic [YW-1:0]     lane_y [KERNEL_SIZE];

  logic              transfer;
  logic              read_valid_d;
  logic              read_valid_q;
  logic [AWIDTH-1:0] read_data_d;
  logic [AWIDTH-1:0] read_data_q;

  // in_ready is a registered flag, so a transfer never depends combinationally
  // on anything but in_valid and flop outputs.
  assign transfer = in_valid && in_ready_q;

  // Per-lane target coordinates and adders: lane (i,j) updates pixel
  // (win_y+i, win_x+j); all lanes of one patch hit distinct pixels.
  for (genvar i = 0; i < KERNEL_SIZE; i++) begin : g_row
    assign lane_y[i] = win_y_q + YW'(i);
    assign lane_x[i] = win_x_q + XW'(i);
    for (genvar j = 0; j < KERNEL_SIZE; j++) begin : g_col
      assign elem[i][j]   = DWIDTH'(lane_slice(MAX_PATCH_BITS'(in_data), i, j,
                                               KERNEL_SIZE, DWIDTH));
      assign acc_rd[i][j] = acc_q[lane_y[i]][lane_x[j]];
      col2im_sat_add #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
      ) u_add (
        .acc_i  (acc_rd[i][j]),
        .elem_i (elem[i][j]),
        .sum_o  (sum[i][j])
      );
    end
  end

  // Frame FSM: sequences IDLE -> CLEAR -> ACCEPT -> DONE, walks the window
  // origin in raster order and registers the control outputs.
  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      win_x_q    <= '0;
      win_y_q    <= '0;
      clr_row_q  <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          win_x_q <= '0;
          win_y_q <= '0;
          if (start) begin
            state_q   <= CLEAR;
            clr_row_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_row_q == YW'(INPUT_HEIGHT - 1)) begin
            state_q    <= ACCEPT;
            in_ready_q <= 1'b1;
          end else begin
            clr_row_q <= clr_row_q + 1'b1;
          end
        end
        ACCEPT: begin
          if (transfer) begin
            if (win_x_q == XW'(OUT_W - 1)) begin
              win_x_q <= '0;
              if (win_y_q == YW'(OUT_H - 1)) begin
                win_y_q    <= '0;
                state_q    <= DONE;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
              end else begin
                win_y_q <= win_y_q + 1'b1;
              end
            end else begin
              win_x_q <= win_x_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (start) begin
            state_q   <= CLEAR;
            clr_row_q <= '0;
            win_x_q   <= '0;
            win_y_q   <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  // Accumulator storage: row clear during CLEAR, K*K scatter-add on a transfer.
  // NOTE: the accumulator array has no reset; CLEAR zeroes it before every
  // frame, so resetting it would only add fan-out on rst.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      for (int x = 0; x < INPUT_WIDTH; x++) begin
        acc_q[clr_row_q][x] <= '0;
      end
    end else if (transfer) begin
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        for (int j = 0; j < KERNEL_SIZE; j++) begin
          acc_q[lane_y[i]][lane_x[j]] <= sum[i][j];
        end
      end
    end
  end

  // Read port next state: only honoured in DONE; data holds otherwise.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    read_valid_d = (state_q == DONE) && read_en;
    read_data_d  = read_data_q;
    if (read_valid_d) begin
      if (int'(read_x) < INPUT_WIDTH && int'(read_y) < INPUT_HEIGHT) begin
        read_data_d = acc_q[read_y][read_x];
      end else begin
        read_data_d = '0;
      end
    end
  end

  // Read port registers: one-cycle latency, back-to-back capable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_valid_q <= 1'b0;
      read_data_q  <= '0;
    end else begin
      read_valid_q <= read_valid_d;
      read_data_q  <= read_data_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign read_valid = read_valid_q;
  assign read_data  = read_data_q;

endmodule

// File: tb/tb_col2im_accum.sv
// tb_col2im_accum: directed frames for col2im_accum with a read-port
// scoreboard. A second instance with AWIDTH=8 exercises overflow handling.
`timescale 1ns/1ps
module tb_col2im_accum;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] in_data;
  logic        read_en;
  logic [1:0]  read_x;
  logic [1:0]  read_y;
  logic [11:0] read_data;
  logic        read_valid;
  logic        busy;
  logic        done;

  logic        s_start;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [71:0] s_in_data;
  logic        s_read_en;
  logic [1:0]  s_read_x;
  logic [1:0]  s_read_y;
  logic [7:0]  s_read_data;
  logic        s_read_valid;
  logic        s_busy;
  logic        s_done;

  int n_vec;
  int n_bad;
  int cyc;

  typedef struct {
    logic [11:0] val;
    int          cyc;
    string       name;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  rd_exp_t sexp_q[$];

  col2im_accum dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .read_en    (read_en),
    .read_x     (read_x),
    .read_y     (read_y),
    .read_data  (read_data),
    .read_valid (read_valid),
    .busy       (busy),
    .done       (done)
  );

  col2im_accum #(
    .DWIDTH (8),
    .AWIDTH (8)
  ) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .start      (s_start),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .in_data    (s_in_data),
    .read_en    (s_read_en),
    .read_x     (s_read_x),
    .read_y     (s_read_y),
    .read_data  (s_read_data),
    .read_valid (s_read_valid),
    .busy       (s_busy),
    .done       (s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Main-instance read monitor: each read_valid pops one expectation and
  // checks both the value and the one-cycle latency.
  always @(negedge clk) begin
    if (read_valid === 1'b1) begin
      rd_exp_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_read_valid: got data %0d, want no response", read_data);
      end else begin
        e = exp_q.pop_front();
        if (read_data !== e.val || cyc != e.cyc + 1) begin
          n_bad++;
          $display("FAIL %s: got %0d at cycle %0d, want %0d at cycle %0d",
                   e.name, read_data, cyc, e.val, e.cyc + 1);
        end
      end
    end
  end

  // Saturation-instance read monitor.
  always @(negedge clk) begin
    if (s_read_valid === 1'b1) begin
      rd_exp_t e;
      n_vec++;
      if (sexp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sat_unexpected_read_valid: got data %0d, want no response", s_read_data);
      end else begin
        e = sexp_q.pop_front();
        if (12'(s_read_data) !== e.val || cyc != e.cyc + 1) begin
          n_bad++;
          $display("FAIL %s: got %0d at cycle %0d, want %0d at cycle %0d",
                   e.name, s_read_data, cyc, e.val, e.cyc + 1);
        end
      end
    end
  end

  function automatic logic [71:0] mk_patch(input bit distinct, input logic [7:0] v);
    logic [71:0] p;
    for (int k = 0; k < 9; k++) p[k*8 +: 8] = distinct ? 8'(k + 1) : v;
    return p;
  endfunction

  // Start a frame and measure the CLEAR phase (cycles with busy and no in_ready).
  task automatic start_frame(input string tag);
    int n;
    n = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (in_ready !== 1'b1 && n < 20) begin
      check({tag, "_clear_busy"}, 32'(busy), 1);
      n++;
      @(negedge clk);
    end
    check({tag, "_clear_cycles"}, n, 4);
    check({tag, "_accept_busy"}, 32'(busy), 1);
  endtask

  // Send npatch patches; with gaps, two idle cycles follow each transfer,
  // carrying junk data and a start pulse that must both be ignored.
  task automatic send(input string tag, input bit distinct, input logic [7:0] v,
                      input bit gaps, input int npatch);
    for (int p = 0; p < npatch; p++) begin
      check({tag, "_in_ready"}, 32'(in_ready), 1);
      check({tag, "_done_early"}, 32'(done), 0);
      in_data  = mk_patch(distinct, v);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      if (gaps && p < npatch - 1) begin
        for (int g = 0; g < 2; g++) begin
          in_data = mk_patch(1'b0, 8'hA5);
          start   = 1'b1;
          @(negedge clk);
          start = 1'b0;
          check({tag, "_gap_in_ready"}, 32'(in_ready), 1);
        end
      end
    end
    if (npatch == 4) begin
      check({tag, "_done"}, 32'(done), 1);
      check({tag, "_in_ready_after"}, 32'(in_ready), 0);
      check({tag, "_busy_after"}, 32'(busy), 0);
    end
  endtask

  // Issue one read this cycle; read_en stays high until read_stop.
  task automatic read_px(input string name, input int x, input int y, input int exp);
    rd_exp_t e;
    read_en = 1'b1;
    read_x  = 2'(x);
    read_y  = 2'(y);
    e.val  = 12'(exp);
    e.cyc  = cyc;
    e.name = name;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic read_stop();
    int t;
    read_en = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("read_drain", exp_q.size(), 0);
  endtask

  task automatic check_all_ones(input string tag);
    read_px({tag, "_00"}, 0, 0, 1);
    read_px({tag, "_33"}, 3, 3, 1);
    read_px({tag, "_10"}, 1, 0, 2);
    read_px({tag, "_01"}, 0, 1, 2);
    read_px({tag, "_11"}, 1, 1, 4);
    read_px({tag, "_22"}, 2, 2, 4);
    read_px({tag, "_30"}, 3, 0, 1);
    read_px({tag, "_23"}, 2, 3, 2);
    read_stop();
  endtask

  initial begin
    rd_exp_t e;
    int n;
    n_vec = 0; n_bad = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    read_en = 1'b0; read_x = '0; read_y = '0;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_data = '0;
    s_read_en = 1'b0; s_read_x = '0; s_read_y = '0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_read_valid", 32'(read_valid), 0);
    check("rst_read_data", 32'(read_data), 0);
    rst = 1'b0;
    @(negedge clk);

    // Read in IDLE is ignored.
    read_en = 1'b1; read_x = 2'd1; read_y = 2'd1;
    @(negedge clk);
    read_en = 1'b0;
    check("idle_read_valid", 32'(read_valid), 0);
    check("idle_read_data", 32'(read_data), 0);

    // All-ones frame, continuous in_valid.
    start_frame("ones");
    send("ones", 1'b0, 8'd1, 1'b0, 4);
    check_all_ones("ones");

    // Same frame with gaps; read in ACCEPT must not respond and data holds.
    start_frame("gaps");
    read_en = 1'b1; read_x = 2'd0; read_y = 2'd0;
    @(negedge clk);
    read_en = 1'b0;
    check("accept_read_valid", 32'(read_valid), 0);
    check("accept_read_hold", 32'(read_data), 2);
    send("gaps", 1'b0, 8'd1, 1'b1, 4);
    check_all_ones("gaps");

    // Distinct element values: (i,j) carries 3*i+j+1.
    start_frame("dist");
    send("dist", 1'b1, 8'd0, 1'b0, 4);
    read_px("dist_00", 0, 0, 1);
    read_px("dist_30", 3, 0, 3);
    read_px("dist_03", 0, 3, 7);
    read_px("dist_33", 3, 3, 9);
    read_px("dist_11", 1, 1, 12);
    read_px("dist_12", 1, 2, 24);
    read_px("dist_10", 1, 0, 3);
    read_px("dist_01", 0, 1, 5);
    read_stop();

    // All-fives frame, then restart with all ones: no carry-over.
    start_frame("fives");
    send("fives", 1'b0, 8'd5, 1'b0, 4);
    read_px("fives_00", 0, 0, 5);
    read_px("fives_11", 1, 1, 20);
    read_stop();
    start_frame("restart");
    send("restart", 1'b0, 8'd1, 1'b0, 4);
    check_all_ones("restart");

    // Reset after two transfers, then a clean frame.
    start_frame("midrst");
    send("midrst", 1'b0, 8'd7, 1'b0, 2);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle_in_ready", 32'(in_ready), 0);
    start_frame("fresh");
    send("fresh", 1'b0, 8'd1, 1'b0, 4);
    check_all_ones("fresh");

    // Overflow: AWIDTH=8, all elements 255.
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n = 0;
    while (s_in_ready !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("sat_clear_cycles", n, 4);
    s_in_data  = {9{8'hFF}};
    s_in_valid = 1'b1;
    repeat (4) @(negedge clk);
    s_in_valid = 1'b0;
    check("sat_done", 32'(s_done), 1);
    check("sat_busy_after", 32'(s_busy), 0);
    s_read_en = 1'b1;
    s_read_x = 2'd1; s_read_y = 2'd1;
`ifdef COL2IM_SAT_EN
    e.val = 12'd255;
`else
    e.val = 12'd252;
`endif
    e.cyc = cyc; e.name = "sat_11";
    sexp_q.push_back(e);
    @(negedge clk);
    s_read_x = 2'd1; s_read_y = 2'd0;
`ifdef COL2IM_SAT_EN
    e.val = 12'd255;
`else
    e.val = 12'd254;
`endif
    e.cyc = cyc; e.name = "sat_10";
    sexp_q.push_back(e);
    @(negedge clk);
    s_read_x = 2'd0; s_read_y = 2'd0;
    e.val = 12'd255; e.cyc = cyc; e.name = "sat_00";
    sexp_q.push_back(e);
    @(negedge clk);
    s_read_en = 1'b0;
    n = 0;
    while (sexp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("sat_read_drain", sexp_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
